// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: arbitrates two transfer requesters onto one SPI byte shift
// engine, walking TX/RX buffers and driving the matching chip select.
module spi_xfer_sched #(
  parameter int unsigned BUF_AW = 9
) (
  input  logic              FastClk,
  input  logic              Reset,
  input  logic              Req0Start,
  input  logic              Req1Start,
  input  logic [BUF_AW-1:0] Req0Len,
  input  logic [BUF_AW-1:0] Req1Len,
  input  logic [1:0]        Req0Dev,
  input  logic [1:0]        Req1Dev,
  input  logic [1:0]        Req0Mode,
  input  logic [1:0]        Req1Mode,
  input  logic              Req0Abort,
  output logic              Busy,
  output logic              Owner,
  output logic [1:0]        Done,
  output logic              Aborted,
  output logic [BUF_AW-1:0] TxAddr,
  input  logic [7:0]        TxData,
  output logic [BUF_AW-1:0] RxAddr,
  output logic [7:0]        RxData,
  output logic              RxWe,
  output logic              ShiftStart,
  output logic [7:0]        ShiftOut,
  input  logic [7:0]        ShiftIn,
  input  logic              ShiftDone,
  output logic              nFlashSel,
  output logic              nMCUSel,
  output logic              nTFSel
);

  localparam logic [1:0] MODE_WR = 2'd0;
  localparam logic [1:0] MODE_RD = 2'd1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    FETCH = 3'd2,
    SHIFT = 3'd3,
    STORE = 3'd4,
    DESEL = 3'd5
  } state_t;

  state_t            r_state, w_state_nx;
  logic              r_pend0, w_pend0_nx;
  logic              r_pend1, w_pend1_nx;
  logic              r_last, w_last_nx;
  logic              r_owner, w_owner_nx;
  logic [BUF_AW-1:0] r_len, w_len_nx;
  logic [BUF_AW-1:0] r_cnt, w_cnt_nx;
  logic [1:0]        r_mode, w_mode_nx;
  logic              r_abort, w_abort_nx;
  logic              r_busy, w_busy_nx;
  logic [1:0]        r_done, w_done_nx;
  logic              r_aborted, w_aborted_nx;
  logic              r_rx_we, w_rx_we_nx;
  logic [BUF_AW-1:0] r_rx_addr, w_rx_addr_nx;
  logic [7:0]        r_rx_data, w_rx_data_nx;
  logic              r_shift_start, w_shift_start_nx;
  logic [2:0]        r_sel_n, w_sel_n_nx;  // {TF, MCU, Flash}, active low

  logic              w_active;
  logic              w_idle_abort;
  logic              w_pend0_eff;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_abort_req;
  logic              w_abort_any;
  logic [BUF_AW-1:0] w_req_len;
  logic [1:0]        w_req_dev;
  logic [1:0]        w_req_mode;

  // One-hot active-low select for a device code; code 0 selects nothing.
  function automatic logic [2:0] sel_decode(input logic [1:0] dev);
    logic [2:0] sel_n;
    case (dev)
      2'd1:    sel_n = 3'b110;
      2'd2:    sel_n = 3'b101;
      2'd3:    sel_n = 3'b011;
      default: sel_n = 3'b111;
    endcase
    return sel_n;
  endfunction

  // Arbitration: an abort seen in IDLE kills a pending request 0 before it
  // can be granted; on contention the requester not served last wins.
  assign w_active     = (r_state != IDLE);
  assign w_idle_abort = ~w_active & Req0Abort;
  assign w_pend0_eff  = r_pend0 & ~w_idle_abort;
  assign w_grant0     = ~w_active & w_pend0_eff & (~r_pend1 | r_last);
  assign w_grant1     = ~w_active & r_pend1 & (~w_pend0_eff | ~r_last);
  assign w_abort_req  = Req0Abort & ~r_owner & w_active;
  assign w_abort_any  = r_abort | w_abort_req;
  assign w_req_len    = w_grant1 ? Req1Len  : Req0Len;
  assign w_req_dev    = w_grant1 ? Req1Dev  : Req0Dev;
  assign w_req_mode   = w_grant1 ? Req1Mode : Req0Mode;

  // State and output registers.
  always_ff @(posedge FastClk) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_pend0       <= 1'b0;
      r_pend1       <= 1'b0;
      r_last        <= 1'b1;
      r_owner       <= 1'b0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_mode        <= MODE_WR;
      r_abort       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 2'b00;
      r_aborted     <= 1'b0;
      r_rx_we       <= 1'b0;
      r_rx_addr     <= '0;
      r_rx_data     <= 8'h00;
      r_shift_start <= 1'b0;
      r_sel_n       <= 3'b111;
    end else begin
      r_state       <= w_state_nx;
      r_pend0       <= w_pend0_nx;
      r_pend1       <= w_pend1_nx;
      r_last        <= w_last_nx;
      r_owner       <= w_owner_nx;
      r_len         <= w_len_nx;
      r_cnt         <= w_cnt_nx;
      r_mode        <= w_mode_nx;
      r_abort       <= w_abort_nx;
      r_busy        <= w_busy_nx;
      r_done        <= w_done_nx;
      r_aborted     <= w_aborted_nx;
      r_rx_we       <= w_rx_we_nx;
      r_rx_addr     <= w_rx_addr_nx;
      r_rx_data     <= w_rx_data_nx;
      r_shift_start <= w_shift_start_nx;
      r_sel_n       <= w_sel_n_nx;
    end
  end

  // Next-state, pending-flag and registered-output logic.
  always_comb begin
    w_state_nx       = r_state;
    w_last_nx        = r_last;
    w_owner_nx       = r_owner;
    w_len_nx         = r_len;
    w_cnt_nx         = r_cnt;
    w_mode_nx        = r_mode;
    w_abort_nx       = w_abort_any;
    w_busy_nx        = r_busy;
    w_done_nx        = 2'b00;
    w_aborted_nx     = 1'b0;
    w_rx_we_nx       = 1'b0;
    w_rx_addr_nx     = r_rx_addr;
    w_rx_data_nx     = r_rx_data;
    w_shift_start_nx = 1'b0;
    w_sel_n_nx       = r_sel_n;

    // A Start for a requester that is already pending or being served is dropped.
    w_pend0_nx = r_pend0 | (Req0Start & ~(w_active & ~r_owner));
    w_pend1_nx = r_pend1 | (Req1Start & ~(w_active & r_owner));
    if (w_grant0 || w_idle_abort) w_pend0_nx = 1'b0;
    if (w_grant1)                 w_pend1_nx = 1'b0;

    case (r_state)
      IDLE: begin
        w_abort_nx = 1'b0;
        if (w_grant0 || w_grant1) begin
          w_owner_nx = w_grant1;
          w_last_nx  = w_grant1;
          w_len_nx   = w_req_len;
          w_mode_nx  = w_req_mode;
          w_cnt_nx   = '0;
          w_busy_nx  = 1'b1;
          w_sel_n_nx = sel_decode(w_req_dev);
          w_state_nx = SEL;
        end
      end
      SEL: begin
        w_state_nx = FETCH;
      end
      FETCH: begin
        w_shift_start_nx = 1'b1;
        w_state_nx       = SHIFT;
      end
      SHIFT: begin
        if (ShiftDone) begin
          w_rx_we_nx   = (r_mode != MODE_WR);
          w_rx_addr_nx = r_cnt;
          w_rx_data_nx = ShiftIn;
          w_state_nx   = STORE;
        end
      end
      STORE: begin
        if ((r_cnt == r_len) || w_abort_any) begin
          w_state_nx = DESEL;
        end else begin
          w_cnt_nx   = r_cnt + BUF_AW'(1);
          w_state_nx = FETCH;
        end
      end
      DESEL: begin
        w_done_nx[r_owner] = 1'b1;
        w_aborted_nx       = ~r_owner & w_abort_any;
        w_abort_nx         = 1'b0;
        w_busy_nx          = 1'b0;
        w_sel_n_nx         = 3'b111;
        w_state_nx         = IDLE;
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_sel_n_nx = 3'b111;
        w_state_nx = IDLE;
      end
    endcase
  end

  // TxData lands one cycle after TxAddr, i.e. in the first SHIFT cycle, so
  // ShiftOut passes it straight through to line up with ShiftStart.
  assign ShiftOut   = (r_mode == MODE_RD) ? 8'hFF : TxData;

  assign Busy       = r_busy;
  assign Owner      = r_owner;
  assign Done       = r_done;
  assign Aborted    = r_aborted;
  assign TxAddr     = r_cnt;
  assign RxAddr     = r_rx_addr;
  assign RxData     = r_rx_data;
  assign RxWe       = r_rx_we;
  assign ShiftStart = r_shift_start;
  assign nFlashSel  = r_sel_n[0];
  assign nMCUSel    = r_sel_n[1];
  assign nTFSel     = r_sel_n[2];

endmodule
